// File: rtl/des_pkg.sv
// Shared DES constants: PC-1/PC-2 selection tables, the left-shift schedule,
// the key-schedule state encoding and 28-bit half rotation helpers.
package des_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Entries are DES bit numbers (1 = MSB of the source word).
  localparam logic [6:0] PC1 [0:55] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  localparam logic [5:0] PC2 [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  // SHIFTS[k] is the rotation applied to produce key K(k+1).
  localparam logic [1:0] SHIFTS [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] amt);
    logic [27:0] r;
    case (amt)
      2'd1:    r = {x[26:0], x[27]};
      2'd2:    r = {x[25:0], x[27:26]};
      default: r = x;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] amt);
    logic [27:0] r;
    case (amt)
      2'd1:    r = {x[0], x[27:1]};
      2'd2:    r = {x[1:0], x[27:2]};
      default: r = x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Permuted Choice 2: selects the 48 subkey bits from the 56-bit {C,D} pair.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  // Pure bit selection; source index converts DES numbering to vector index.
  always_comb begin
    subkey = 48'd0;
    for (int i = 0; i < 48; i++) begin
      subkey[47-i] = cd[6'd56 - PC2[i]];
    end
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on load, then one PC-2 subkey per handshake
// in encrypt (K1..K16) or decrypt (K16..K1) order.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        load,
  input  logic        subkey_ready,
  output logic [47:0] subkey_out,
  output logic        subkey_valid,
  output logic [3:0]  round_num,
  output logic        busy,
  output logic        done
);

  state_t      state_r;
  logic [27:0] c_r, d_r;
  logic [3:0]  cnt_r;
  logic        dec_r;
  logic        done_r;

  logic [55:0] pc1_s;
  logic [47:0] pc2_s;
  logic [1:0]  amt_s;
  logic [27:0] c_next_s, d_next_s;

  // PC-1 selection from the incoming key; parity bits are simply never picked.
  always_comb begin
    pc1_s = 56'd0;
    for (int i = 0; i < 56; i++) begin
      pc1_s[55-i] = key_in[6'(7'd64 - PC1[i])];
    end
  end

  // Next rotation; at cnt 15 the encrypt index wraps but the result is unused.
  always_comb begin
    if (dec_r) begin
      amt_s    = SHIFTS[4'd15 - cnt_r];
      c_next_s = rotr28(c_r, amt_s);
      d_next_s = rotr28(d_r, amt_s);
    end else begin
      amt_s    = SHIFTS[cnt_r + 4'd1];
      c_next_s = rotl28(c_r, amt_s);
      d_next_s = rotl28(d_r, amt_s);
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_r, d_r}),
    .subkey (pc2_s)
  );

  // Control FSM and C/D half registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      c_r     <= 28'd0;
      d_r     <= 28'd0;
      cnt_r   <= 4'd0;
      dec_r   <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (load) begin
            dec_r   <= decrypt;
            cnt_r   <= 4'd0;
            state_r <= ST_RUN;
            // Decrypt starts at C16/D16, which equal C0/D0 after 28 total shifts.
            if (decrypt) begin
              c_r <= pc1_s[55:28];
              d_r <= pc1_s[27:0];
            end else begin
              c_r <= rotl28(pc1_s[55:28], 2'd1);
              d_r <= rotl28(pc1_s[27:0], 2'd1);
            end
          end
        end
        ST_RUN: begin
          if (subkey_ready) begin
            c_r   <= c_next_s;
            d_r   <= d_next_s;
            cnt_r <= cnt_r + 4'd1;
            if (cnt_r == 4'd15) begin
              state_r <= ST_IDLE;
              done_r  <= 1'b1;
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign subkey_valid = (state_r == ST_RUN);
  assign busy         = (state_r == ST_RUN);
  assign subkey_out   = subkey_valid ? pc2_s : 48'd0;
  assign round_num    = cnt_r;
  assign done         = done_r;

endmodule

// File: tb/tb_des_key_schedule.sv
// Scoreboard bench for des_key_schedule: stimulus pushes expected subkeys,
// a negedge monitor pops and compares on every transfer.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] key_in;
  logic        decrypt;
  logic        load;
  logic        subkey_ready;
  logic [47:0] subkey_out;
  logic        subkey_valid;
  logic [3:0]  round_num;
  logic        busy;
  logic        done;

  localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
  localparam logic [63:0] KEY_PAR = 64'h123456789ABCDEF0;
  localparam logic [63:0] KEY_B   = 64'h0E329232EA6D0D73;

  localparam logic [47:0] KEXP [0:15] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  rnd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vcycles  = 0;

  des_key_schedule dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .decrypt      (decrypt),
    .load         (load),
    .subkey_ready (subkey_ready),
    .subkey_out   (subkey_out),
    .subkey_valid (subkey_valid),
    .round_num    (round_num),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: compare every transfer against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (subkey_valid) vcycles++;
    if (subkey_valid && subkey_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_subkey: got %h with no expected entry", subkey_out);
      end else begin
        e = sb_q.pop_front();
        chk("subkey", {16'd0, subkey_out}, {16'd0, e.key});
        chk("round_num", {60'd0, round_num}, {60'd0, e.rnd});
      end
    end else if (!subkey_valid) begin
      chk("subkey_zero_idle", {16'd0, subkey_out}, 64'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic dec);
    for (int i = 0; i < 16; i++) begin
      sb_q.push_back({dec ? KEXP[15-i] : KEXP[i], 4'(i)});
    end
  endtask

  task automatic start(input logic [63:0] key, input logic dec);
    push_seq(dec);
    key_in  = key;
    decrypt = dec;
    load    = 1'b1;
    tick();
    load = 1'b0;
    chk("busy_after_load", {63'd0, busy}, 64'd1);
    chk("valid_after_load", {63'd0, subkey_valid}, 64'd1);
  endtask

  task automatic check_done_cycle(input string tag);
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_busy_low"}, {63'd0, busy}, 64'd0);
    chk({tag, "_valid_low"}, {63'd0, subkey_valid}, 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_subkey"}, {16'd0, subkey_out}, 64'd0);
    chk({tag, "_valid"}, {63'd0, subkey_valid}, 64'd0);
    chk({tag, "_round"}, {60'd0, round_num}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; load = 1'b0; decrypt = 1'b0; subkey_ready = 1'b1; key_in = 64'd0;
    #1 rst = 1'b1;
    #2 check_all_zero("reset");
    tick(); tick();
    rst = 1'b0;

    // Encrypt with ready held high.
    start(KEY_A, 1'b0);
    chk("enc_first", {16'd0, subkey_out}, {16'd0, KEXP[0]});
    repeat (16) tick();
    check_done_cycle("enc");
    tick();
    chk("enc_done_pulse_end", {63'd0, done}, 64'd0);

    // Decrypt order.
    start(KEY_A, 1'b1);
    chk("dec_first", {16'd0, subkey_out}, {16'd0, KEXP[15]});
    repeat (16) tick();
    check_done_cycle("dec");
    tick();

    // Backpressure at round 4 for three cycles.
    vcycles = 0;
    start(KEY_A, 1'b0);
    repeat (4) tick();
    subkey_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_round", {60'd0, round_num}, 64'd4);
      chk("bp_hold_key", {16'd0, subkey_out}, {16'd0, KEXP[4]});
    end
    subkey_ready = 1'b1;
    repeat (12) tick();
    check_done_cycle("bp");
    chk("bp_valid_cycles", 64'(vcycles), 64'd19);
    tick();

    // Reset mid-sequence, then restart.
    start(KEY_A, 1'b0);
    repeat (7) tick();
    chk("pre_reset_round", {60'd0, round_num}, 64'd7);
    rst = 1'b1;
    #1 check_all_zero("midreset");
    sb_q.delete();
    tick();
    rst = 1'b0;
    tick();
    chk("no_done_after_reset", {63'd0, done}, 64'd0);
    start(KEY_A, 1'b0);
    chk("restart_k1", {16'd0, subkey_out}, {16'd0, KEXP[0]});
    repeat (16) tick();
    check_done_cycle("restart");
    tick();

    // Load while busy is ignored; load in the done cycle is accepted.
    start(KEY_A, 1'b0);
    load = 1'b1; key_in = KEY_B; decrypt = 1'b1;
    repeat (15) tick();
    key_in = KEY_A; decrypt = 1'b0;
    push_seq(1'b0);
    tick();
    check_done_cycle("busyload");
    tick();
    load = 1'b0;
    chk("doneload_valid", {63'd0, subkey_valid}, 64'd1);
    chk("doneload_k1", {16'd0, subkey_out}, {16'd0, KEXP[0]});
    repeat (16) tick();
    check_done_cycle("doneload");
    tick();

    // Parity bits do not influence the schedule.
    start(KEY_PAR, 1'b0);
    repeat (16) tick();
    check_done_cycle("parity");
    tick();

    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
